// File: rtl/jtkicker_sdram_ctrl.sv
// SDRAM responder for the game ROM read bus and the download write path.
// Single 16-bit SDR chip: power-up init, periodic auto-refresh, BL2 reads, single-word writes.
module jtkicker_sdram_ctrl #(
  parameter int unsigned TRCD       = 2,
  parameter int unsigned CL         = 2,
  parameter int unsigned TRP        = 2,
  parameter int unsigned TWR        = 2,
  parameter int unsigned TRFC       = 7,
  parameter int unsigned REF_PERIOD = 370,
  parameter int unsigned INIT_WAIT  = 4800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic [15:0] data_read,
  output logic        data_dst,
  output logic        data_rdy,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  output logic        init_done,
  output logic [3:0]  sd_cmd,
  output logic [1:0]  sd_ba,
  output logic [12:0] sd_a,
  output logic [1:0]  sd_dqm,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  input  logic [15:0] sd_dq_in,
  output logic        sd_cke
);

  localparam logic [3:0] CmdNop   = 4'b0111;
  localparam logic [3:0] CmdAct   = 4'b0011;
  localparam logic [3:0] CmdRead  = 4'b0101;
  localparam logic [3:0] CmdWrite = 4'b0100;
  localparam logic [3:0] CmdPre   = 4'b0010;
  localparam logic [3:0] CmdRef   = 4'b0001;
  localparam logic [3:0] CmdMrs   = 4'b0000;

  // Burst length 2, sequential, CAS latency CL, single-word writes.
  localparam logic [12:0] ModeReg = {3'b000, 1'b1, 2'b00, 3'(CL), 1'b0, 3'b001};

  // Operation lengths counted from the ACT/REF cycle (cnt = 1) to the last busy cycle.
  localparam int unsigned RdLen = TRCD + CL + 2 + TRP;
  localparam int unsigned WrLen = TRCD + TWR + TRP;

  typedef enum logic [2:0] {
    StInitWait, StInitPre, StInitRef, StInitMrs, StIdle, StRead, StWrite, StRefresh
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ref_step_q, ref_step_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        ref_pend_q, ref_pend_d;
  logic [1:0]  ba_q, ba_d;
  logic [7:0]  col_q, col_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  wmask_q, wmask_d;

  logic [3:0]  sd_cmd_q, sd_cmd_d;
  logic [1:0]  sd_ba_q, sd_ba_d;
  logic [12:0] sd_a_q, sd_a_d;
  logic [1:0]  sd_dqm_q, sd_dqm_d;
  logic [15:0] sd_dq_out_q, sd_dq_out_d;
  logic        sd_dq_oe_q, sd_dq_oe_d;
  logic        sd_cke_q, sd_cke_d;
  logic        sdram_ack_q, sdram_ack_d;
  logic        data_dst_q, data_dst_d;
  logic        data_rdy_q, data_rdy_d;
  logic [15:0] data_read_q, data_read_d;
  logic        init_done_q, init_done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    ref_step_d  = ref_step_q;
    ref_cnt_d   = ref_cnt_q;
    ref_pend_d  = ref_pend_q;
    ba_d        = ba_q;
    col_d       = col_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    sd_cmd_d    = CmdNop;
    sd_ba_d     = sd_ba_q;
    sd_a_d      = sd_a_q;
    sd_dqm_d    = 2'b11;
    sd_dq_out_d = sd_dq_out_q;
    sd_dq_oe_d  = 1'b0;
    sd_cke_d    = 1'b1;
    sdram_ack_d = 1'b0;
    data_dst_d  = 1'b0;
    data_rdy_d  = 1'b0;
    data_read_d = data_read_q;
    init_done_d = init_done_q;

    unique case (state_q)
      StInitWait: if (cnt_q == 16'(INIT_WAIT - 1)) begin
        sd_cmd_d = CmdPre;
        sd_a_d   = 13'h0400;
        state_d  = StInitPre;
        cnt_d    = 16'd1;
      end
      StInitPre: if (cnt_q == 16'(TRP)) begin
        sd_cmd_d   = CmdRef;
        ref_step_d = 1'b0;
        state_d    = StInitRef;
        cnt_d      = 16'd1;
      end
      StInitRef: if (cnt_q == 16'(TRFC)) begin
        cnt_d = 16'd1;
        if (!ref_step_q) begin
          sd_cmd_d   = CmdRef;
          ref_step_d = 1'b1;
        end else begin
          sd_cmd_d = CmdMrs;
          sd_ba_d  = 2'b00;
          sd_a_d   = ModeReg;
          state_d  = StInitMrs;
        end
      end
      StInitMrs: if (cnt_q == 16'd2) begin
        init_done_d = 1'b1;
        state_d     = StIdle;
      end
      StIdle: begin
        cnt_d = 16'd1;
        if (ref_pend_q) begin
          sd_cmd_d   = CmdRef;
          ref_pend_d = 1'b0;
          state_d    = StRefresh;
        end else if (downloading && prog_we) begin
          sd_cmd_d    = CmdAct;
          sdram_ack_d = 1'b1;
          sd_ba_d     = prog_addr[21:20];
          sd_a_d      = {1'b0, prog_addr[19:8]};
          ba_d        = prog_addr[21:20];
          col_d       = prog_addr[7:0];
          wdata_d     = prog_data;
          wmask_d     = prog_mask;
          state_d     = StWrite;
        end else if (!downloading && sdram_req) begin
          sd_cmd_d    = CmdAct;
          sdram_ack_d = 1'b1;
          sd_ba_d     = sdram_addr[21:20];
          sd_a_d      = {1'b0, sdram_addr[19:8]};
          ba_d        = sdram_addr[21:20];
          col_d       = sdram_addr[7:0];
          state_d     = StRead;
        end
      end
      StRead: begin
        if (cnt_q == 16'(TRCD)) begin
          sd_cmd_d = CmdRead;
          sd_ba_d  = ba_q;
          sd_a_d   = {2'b00, 1'b1, 2'b00, col_q};
        end
        // Unmask from the READ cycle through the last burst word.
        if (cnt_q >= 16'(TRCD) && cnt_q <= 16'(TRCD + CL + 1)) sd_dqm_d = 2'b00;
        if (cnt_q == 16'(TRCD + CL + 1)) begin
          data_read_d = sd_dq_in;
          data_dst_d  = 1'b1;
        end
        if (cnt_q == 16'(TRCD + CL + 2)) begin
          data_read_d = sd_dq_in;
          data_rdy_d  = 1'b1;
        end
        if (cnt_q == 16'(RdLen)) state_d = StIdle;
      end
      StWrite: begin
        if (cnt_q == 16'(TRCD)) begin
          sd_cmd_d    = CmdWrite;
          sd_ba_d     = ba_q;
          sd_a_d      = {2'b00, 1'b1, 2'b00, col_q};
          sd_dq_oe_d  = 1'b1;
          sd_dq_out_d = wdata_q;
          sd_dqm_d    = wmask_q;
        end
        if (cnt_q == 16'(WrLen)) state_d = StIdle;
      end
      StRefresh: if (cnt_q == 16'(TRFC)) state_d = StIdle;
      default: state_d = StInitWait;
    endcase

    // Placed after the arbiter so a wrap on the serving cycle is not lost.
    if (init_done_q) begin
      if (ref_cnt_q == 16'(REF_PERIOD - 1)) begin
        ref_cnt_d  = 16'd0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInitWait;
      cnt_q       <= 16'd0;
      ref_step_q  <= 1'b0;
      ref_cnt_q   <= 16'd0;
      ref_pend_q  <= 1'b0;
      ba_q        <= 2'b00;
      col_q       <= 8'd0;
      wdata_q     <= 16'd0;
      wmask_q     <= 2'b11;
      sd_cmd_q    <= CmdNop;
      sd_ba_q     <= 2'b00;
      sd_a_q      <= 13'd0;
      sd_dqm_q    <= 2'b11;
      sd_dq_out_q <= 16'd0;
      sd_dq_oe_q  <= 1'b0;
      sd_cke_q    <= 1'b1;
      sdram_ack_q <= 1'b0;
      data_dst_q  <= 1'b0;
      data_rdy_q  <= 1'b0;
      data_read_q <= 16'd0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_step_q  <= ref_step_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      ba_q        <= ba_d;
      col_q       <= col_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      sd_cmd_q    <= sd_cmd_d;
      sd_ba_q     <= sd_ba_d;
      sd_a_q      <= sd_a_d;
      sd_dqm_q    <= sd_dqm_d;
      sd_dq_out_q <= sd_dq_out_d;
      sd_dq_oe_q  <= sd_dq_oe_d;
      sd_cke_q    <= sd_cke_d;
      sdram_ack_q <= sdram_ack_d;
      data_dst_q  <= data_dst_d;
      data_rdy_q  <= data_rdy_d;
      data_read_q <= data_read_d;
      init_done_q <= init_done_d;
    end
  end

  assign sd_cmd    = sd_cmd_q;
  assign sd_ba     = sd_ba_q;
  assign sd_a      = sd_a_q;
  assign sd_dqm    = sd_dqm_q;
  assign sd_dq_out = sd_dq_out_q;
  assign sd_dq_oe  = sd_dq_oe_q;
  assign sd_cke    = sd_cke_q;
  assign sdram_ack = sdram_ack_q;
  assign data_dst  = data_dst_q;
  assign data_rdy  = data_rdy_q;
  assign data_read = data_read_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_jtkicker_sdram_ctrl.sv
// Directed bench for jtkicker_sdram_ctrl: table of read/write vectors plus
// hand-written init, refresh, blocking and reset sequences against a small chip model.
module tb_jtkicker_sdram_ctrl;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  localparam int TCL = 2, TTRP = 2, TTRFC = 7, TINIT = 4800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        sdram_req = 1'b0;
  logic [21:0] sdram_addr = '0;
  logic        sdram_ack;
  logic [15:0] data_read;
  logic        data_dst, data_rdy;
  logic        prog_we = 1'b0;
  logic [21:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [1:0]  prog_mask = 2'b11;
  logic        init_done;
  logic [3:0]  sd_cmd;
  logic [1:0]  sd_ba;
  logic [12:0] sd_a;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;
  logic [15:0] sd_dq_in = 16'hFFFF;
  logic        sd_cke;

  always #5 clk = ~clk;

  jtkicker_sdram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_read(data_read), .data_dst(data_dst), .data_rdy(data_rdy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .init_done(init_done), .sd_cmd(sd_cmd), .sd_ba(sd_ba), .sd_a(sd_a), .sd_dqm(sd_dqm),
    .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe), .sd_dq_in(sd_dq_in), .sd_cke(sd_cke)
  );

  // Chip model: drives the two burst words CL and CL+1 cycles after a READ.
  logic [15:0] w0 = 16'h0, w1 = 16'h0;
  int rd_age = 100;
  always @(negedge clk) begin
    if (sd_cmd == RD) rd_age = 0;
    else if (rd_age < 100) rd_age++;
    if (rd_age == TCL) sd_dq_in = w0;
    else if (rd_age == TCL + 1) sd_dq_in = w1;
    else sd_dq_in = 16'hFFFF;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd"}, 32'(sd_cmd), 32'(NOP));
    check({tag, "_ba"}, 32'(sd_ba), 0);
    check({tag, "_a"}, 32'(sd_a), 0);
    check({tag, "_dqm"}, 32'(sd_dqm), 3);
    check({tag, "_oe"}, 32'(sd_dq_oe), 0);
    check({tag, "_dqout"}, 32'(sd_dq_out), 0);
    check({tag, "_cke"}, 32'(sd_cke), 1);
    check({tag, "_ack"}, 32'(sdram_ack), 0);
    check({tag, "_dst"}, 32'(data_dst), 0);
    check({tag, "_rdy"}, 32'(data_rdy), 0);
    check({tag, "_rdata"}, 32'(data_read), 0);
    check({tag, "_initdone"}, 32'(init_done), 0);
  endtask

  // Releases reset and follows the init command sequence up to init_done.
  task automatic run_init(input string tag);
    int pre_k, ref1, ref2, mrs_k, done_k, other;
    logic [12:0] pre_a, mrs_a;
    pre_k = -1; ref1 = -1; ref2 = -1; mrs_k = -1; done_k = -1; other = 0;
    pre_a = '0; mrs_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= TINIT + 100 && done_k < 0; k++) begin
      @(negedge clk);
      if (sd_cmd == PRE && pre_k < 0) begin pre_k = k; pre_a = sd_a; end
      else if (sd_cmd == REF && ref1 < 0) ref1 = k;
      else if (sd_cmd == REF && ref2 < 0) ref2 = k;
      else if (sd_cmd == MRS && mrs_k < 0) begin mrs_k = k; mrs_a = sd_a; end
      else if (sd_cmd != NOP) other++;
      if (init_done && done_k < 0) done_k = k;
    end
    check({tag, "_pre_time"}, 32'(pre_k), 32'(TINIT));
    check({tag, "_pre_a10"}, 32'(pre_a[10]), 1);
    check({tag, "_ref1_gap"}, 32'(ref1 - pre_k), 32'(TTRP));
    check({tag, "_ref2_gap"}, 32'(ref2 - ref1), 32'(TTRFC));
    check({tag, "_mrs_gap"}, 32'(mrs_k - ref2), 32'(TTRFC));
    check({tag, "_mrs_a"}, 32'(mrs_a), 32'h221);
    check({tag, "_done_gap"}, 32'(done_k - mrs_k), 2);
    check({tag, "_other_cmds"}, 32'(other), 0);
  endtask

  typedef struct {
    logic        wr;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;
    logic [15:0] d0, d1;
    logic [1:0]  exp_ba;
    logic [12:0] exp_row;
    logic [12:0] exp_col;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int act_k, rw_k, dst_k, rdy_k, acks, oes;
    string p;
    p = $sformatf("v%0d", idx);
    act_k = -1; rw_k = -1; dst_k = -1; rdy_k = -1; acks = 0; oes = 0;
    @(negedge clk);
    w0 = v.d0; w1 = v.d1;
    if (v.wr) begin
      downloading = 1'b1; prog_we = 1'b1; prog_addr = v.addr;
      prog_data = v.wdata; prog_mask = v.mask;
    end else begin
      downloading = 1'b0; sdram_req = 1'b1; sdram_addr = v.addr;
    end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (sdram_ack) begin
        acks++;
        // Drop the request and scramble inputs: the op must use values latched at ACT.
        prog_we = 1'b0; sdram_req = 1'b0;
        prog_addr = ~v.addr; sdram_addr = ~v.addr; prog_data = ~v.wdata; prog_mask = ~v.mask;
      end
      if (sd_cmd == ACT && act_k < 0) begin
        act_k = k;
        check({p, "_act_ba"}, 32'(sd_ba), 32'(v.exp_ba));
        check({p, "_act_row"}, 32'(sd_a), 32'(v.exp_row));
        check({p, "_act_dqm"}, 32'(sd_dqm), 3);
      end
      if (sd_cmd == (v.wr ? WR : RD) && rw_k < 0) begin
        rw_k = k;
        check({p, "_rw_ba"}, 32'(sd_ba), 32'(v.exp_ba));
        check({p, "_rw_col"}, 32'(sd_a), 32'(v.exp_col));
        if (v.wr) begin
          check({p, "_wr_oe"}, 32'(sd_dq_oe), 1);
          check({p, "_wr_dq"}, 32'(sd_dq_out), 32'(v.wdata));
          check({p, "_wr_dqm"}, 32'(sd_dqm), 32'(v.mask));
        end
      end
      if (sd_dq_oe) oes++;
      if (!v.wr && (k == 5 || k == 6)) check({p, "_rd_dqm_window"}, 32'(sd_dqm), 0);
      if (data_dst) begin dst_k = k; check({p, "_word0"}, 32'(data_read), 32'(v.d0)); end
      if (data_rdy) begin rdy_k = k; check({p, "_word1"}, 32'(data_read), 32'(v.d1)); end
    end
    check({p, "_act_cycle"}, 32'(act_k), 1);
    check({p, "_rw_cycle"}, 32'(rw_k), 3);
    check({p, "_acks"}, 32'(acks), 1);
    if (v.wr) begin
      check({p, "_oe_cycles"}, 32'(oes), 1);
    end else begin
      check({p, "_dst_cycle"}, 32'(dst_k), 6);
      check({p, "_rdy_cycle"}, 32'(rdy_k), 7);
    end
    downloading = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int acts, acks, refs_ok, last_act, ref_k, act_k;

    vecs[0] = '{1'b0, 22'h2ABCCD, 16'h0, 2'b11, 16'h1234, 16'h5678, 2'd2, 13'h0ABC, 13'h4CD};
    vecs[1] = '{1'b1, 22'h000100, 16'hABAB, 2'b10, 16'h0, 16'h0, 2'd0, 13'h0001, 13'h400};
    vecs[2] = '{1'b0, 22'h3FFFFF, 16'h0, 2'b11, 16'hA5A5, 16'h5A5A, 2'd3, 13'h0FFF, 13'h4FF};
    vecs[3] = '{1'b1, 22'h1C0302, 16'h1357, 2'b01, 16'h0, 16'h0, 2'd1, 13'h0C03, 13'h402};
    vecs[4] = '{1'b0, 22'h000000, 16'h0, 2'b11, 16'h0000, 16'hFFF0, 2'd0, 13'h0000, 13'h400};
    vecs[5] = '{1'b1, 22'h2000FF, 16'hFFFF, 2'b00, 16'h0, 16'h0, 2'd2, 13'h0000, 13'h4FF};

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    run_init("init");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // A request withdrawn while the controller is busy is never acked.
    acks = 0; acts = 0;
    @(negedge clk);
    downloading = 1'b0; sdram_req = 1'b1; sdram_addr = 22'h012345;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sdram_ack) begin acks++; sdram_req = 1'b0; end
      if (sd_cmd == ACT) acts++;
      if (k == 3) sdram_req = 1'b1;
      if (k == 6) sdram_req = 1'b0;
    end
    check("drop_req_acks", 32'(acks), 1);
    check("drop_req_acts", 32'(acts), 1);

    // Reads are blocked while downloading.
    acks = 0; acts = 0;
    downloading = 1'b1; sdram_req = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sdram_ack) acks++;
      if (sd_cmd == ACT) acts++;
    end
    check("dl_block_acks", 32'(acks), 0);
    check("dl_block_acts", 32'(acts), 0);
    sdram_req = 1'b0; downloading = 1'b0;
    repeat (12) @(negedge clk);

    // Continuous reads: a pending refresh wins the next idle slot, then the read resumes.
    refs_ok = 0; last_act = -1; ref_k = -1;
    sdram_req = 1'b1;
    for (int k = 0; k < 450; k++) begin
      @(negedge clk);
      if (sd_cmd == REF) begin
        ref_k = k;
        if (last_act >= 0) check("ref_after_read", 32'(k - last_act), 9);
      end
      if (sd_cmd == ACT) begin
        if (ref_k >= 0) begin
          check("ref_to_act", 32'(k - ref_k), 8);
          refs_ok++;
          ref_k = -1;
        end
        last_act = k;
      end
    end
    check("ref_seen", 32'(refs_ok >= 1), 1);
    sdram_req = 1'b0;
    repeat (20) @(negedge clk);

    // Asynchronous reset between ACT and READ.
    act_k = -1;
    sdram_req = 1'b1; sdram_addr = 22'h155555;
    for (int k = 1; k <= 30 && act_k < 0; k++) begin
      @(negedge clk);
      if (sd_cmd == ACT) act_k = k;
    end
    check("mid_rst_act_seen", 32'(act_k > 0), 1);
    sdram_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (3) @(negedge clk);
    run_init("reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
